// File: rtl/encoder_channel.sv
// Quadrature encoder input stage: synchronises and debounces the A/B pins,
// then turns each debounced rising edge of A into a saturating level step.
module encoder_channel #(
  parameter int WIDTH  = 8,
  parameter int DB_LEN = 4,
  parameter int STEP   = 1,
  parameter int INIT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam logic [WIDTH:0]   MAX_W  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic              a_meta, a_s, b_meta, b_s;
  logic [DB_LEN-1:0] a_hist, b_hist, a_hist_nx, b_hist_nx;
  logic              a_db, b_db, a_db_nx, b_db_nx, a_db_d;
  logic              detent;
  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  level_nx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path in a combinational block infers a latch).
    a_hist_nx = a_hist;
    b_hist_nx = b_hist;
    a_db_nx   = a_db;
    b_db_nx   = b_db;
    level_nx  = level;

    if (sample_en) begin
      a_hist_nx = {a_hist[DB_LEN-2:0], a_s};
      b_hist_nx = {b_hist[DB_LEN-2:0], b_s};
    end

    // The debounced value follows the history only once it is unanimous.
    if (&a_hist_nx)       a_db_nx = 1'b1;
    else if (~|a_hist_nx) a_db_nx = 1'b0;
    if (&b_hist_nx)       b_db_nx = 1'b1;
    else if (~|b_hist_nx) b_db_nx = 1'b0;

    detent = a_db & ~a_db_d;
    sum    = {1'b0, level} + STEP_W;
    diff   = {1'b0, level} - STEP_W;

    // The extra top bit catches overflow on the way up and borrow on the way down.
    if (detent) begin
      if (b_db) level_nx = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      else      level_nx = (sum > MAX_W) ? '1 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta  <= 1'b0;
      a_s     <= 1'b0;
      b_meta  <= 1'b0;
      b_s     <= 1'b0;
      a_hist  <= '0;
      b_hist  <= '0;
      a_db    <= 1'b0;
      b_db    <= 1'b0;
      a_db_d  <= 1'b0;
      level   <= INIT_W;
      changed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // which is what makes the two synchroniser flops a real two-stage chain.
      a_meta  <= enc_a;
      a_s     <= a_meta;
      b_meta  <= enc_b;
      b_s     <= b_meta;
      a_hist  <= a_hist_nx;
      b_hist  <= b_hist_nx;
      a_db    <= a_db_nx;
      b_db    <= b_db_nx;
      a_db_d  <= a_db;
      level   <= level_nx;
      changed <= (level_nx != level);
    end
  end

endmodule

// File: tb/tb_encoder_channel.sv
// Self-checking bench for encoder_channel: two instances (STEP=1/INIT=0 and
// STEP=16/INIT=0xF5) share one stimulus and are compared against a detent-level model.
module tb_encoder_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic [7:0] level_a, level_b;
  logic       changed_a, changed_b;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int mode     = 0;   // 0: sample every clock, 1: every 8th clock, 2: never
  int chg_a    = 0;
  int chg_b    = 0;
  int last_a   = 0;
  int last_b   = 0;
  int m_a      = 0;
  int m_b      = 8'hF5;

  always #5 clk = ~clk;

  encoder_channel #(.WIDTH(8), .DB_LEN(4), .STEP(1), .INIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .enc_a(enc_a), .enc_b(enc_b),
    .level(level_a), .changed(changed_a)
  );

  encoder_channel #(.WIDTH(8), .DB_LEN(4), .STEP(16), .INIT(8'hF5)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .enc_a(enc_a), .enc_b(enc_b),
    .level(level_b), .changed(changed_b)
  );

  always @(posedge clk) cyc = cyc + 1;

  // sample_en driven here affects the following rising edge (edge number cyc+1).
  always @(negedge clk) begin
    sample_en = (mode == 0) || (mode == 1 && (cyc % 8) == 0);
    if (changed_a) begin chg_a = chg_a + 1; last_a = cyc; end
    if (changed_b) begin chg_b = chg_b + 1; last_b = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int nxt(input int lvl, input int st, input bit down);
    if (down) return (lvl - st < 0) ? 0 : lvl - st;
    return (lvl + st > 255) ? 255 : lvl + st;
  endfunction

  // Edge e sees sample_en high when (e-1)%8==0 in mode 1. A rise driven after
  // edge r reaches a_s at edge r+2; ticks at r+3.. sample it; level follows the
  // fourth such tick by one clock.
  function automatic int exp_latency(input int rise);
    int e, n;
    if (mode == 0) return 7;
    n = 0;
    for (e = rise + 3; e < rise + 200; e++) begin
      if (((e - 1) % 8) == 0) n++;
      if (n == 4) return e + 1 - rise;
    end
    return -1;
  endfunction

  task automatic pulse(input bit down, input int hi, input int lo, input bit live, input string tag);
    int ca, cb, ea, eb, rise;
    ca = chg_a;
    cb = chg_b;
    enc_b = down;
    step(lo);
    enc_a = 1'b1;
    rise  = cyc;
    step(hi);
    ea = live ? nxt(m_a, 1, down)  : m_a;
    eb = live ? nxt(m_b, 16, down) : m_b;
    check({tag, "_level_a"}, level_a, ea);
    check({tag, "_level_b"}, level_b, eb);
    check({tag, "_changes_a"}, chg_a - ca, (ea != m_a) ? 1 : 0);
    check({tag, "_changes_b"}, chg_b - cb, (eb != m_b) ? 1 : 0);
    if (ea != m_a && chg_a - ca == 1) check({tag, "_latency_a"}, last_a - rise, exp_latency(rise));
    if (eb != m_b && chg_b - cb == 1) check({tag, "_latency_b"}, last_b - rise, exp_latency(rise));
    m_a = ea;
    m_b = eb;
    enc_a = 1'b0;
  endtask

  initial begin
    int ca, cb, guard;

    // Reset state
    step(3);
    check("rst_level_a", level_a, 8'h00);
    check("rst_level_b", level_b, 8'hF5);
    check("rst_changed_a", changed_a, 1'b0);
    check("rst_changed_b", changed_b, 1'b0);
    rst_n = 1'b1;
    step(10);
    check("idle_no_change_a", chg_a, 0);

    // Count up: five clean pulses, upper clamp on the STEP=16 instance
    for (int i = 0; i < 5; i++) pulse(1'b0, 10, 10, 1'b1, "up");
    check("up_final_a", level_a, 8'h05);
    check("up_final_b", level_b, 8'hFF);

    // Count down through zero with saturation
    for (int i = 0; i < 7; i++) pulse(1'b1, 10, 10, 1'b1, "down");
    check("down_final_a", level_a, 8'h00);

    // Bounce rejection: toggle every 2 cycles for 40 cycles, then stable high
    ca = chg_a;
    cb = chg_b;
    enc_b = 1'b0;
    step(10);
    for (int i = 0; i < 20; i++) begin
      enc_a = ~enc_a;
      step(2);
    end
    enc_a = 1'b1;
    step(12);
    check("bounce_changes_a", chg_a - ca, 1);
    check("bounce_changes_b", chg_b - cb, (nxt(m_b, 16, 1'b0) != m_b) ? 1 : 0);
    m_a = nxt(m_a, 1, 1'b0);
    m_b = nxt(m_b, 16, 1'b0);
    check("bounce_level_a", level_a, m_a);
    check("bounce_level_b", level_b, m_b);
    enc_a = 1'b0;
    step(10);

    // Prescaled sampling, then sampling frozen
    mode = 1;
    pulse(1'b0, 45, 45, 1'b1, "presc");
    step(45);
    mode = 2;
    pulse(1'b0, 45, 20, 1'b0, "frozen");
    step(20);
    mode = 0;
    step(20);

    // Randomised detents
    for (int i = 0; i < 16; i++)
      pulse(1'($urandom_range(0, 1)), $urandom_range(8, 14), $urandom_range(8, 14), 1'b1, "rand");

    // Walk channel A to 0x37, then reset in the middle of a detent
    guard = 0;
    while (m_a != 8'h37 && guard < 300) begin
      pulse(m_a > 8'h37, 8, 8, 1'b1, "seek");
      guard++;
    end
    check("seek_level_a", level_a, 8'h37);
    enc_b = 1'b0;
    step(10);
    enc_a = 1'b1;
    step(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level_a", level_a, 8'h00);
    check("async_rst_level_b", level_b, 8'hF5);
    check("async_rst_changed_a", changed_a, 1'b0);
    check("async_rst_changed_b", changed_b, 1'b0);
    m_a = 0;
    m_b = 8'hF5;
    enc_a = 1'b0;
    step(3);
    ca = chg_a;
    cb = chg_b;
    rst_n = 1'b1;
    step(20);
    check("post_rst_changes_a", chg_a - ca, 0);
    check("post_rst_changes_b", chg_b - cb, 0);
    check("post_rst_level_a", level_a, 8'h00);
    pulse(1'b0, 10, 10, 1'b1, "post_rst_up");
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
